msgpu_memory_arbiter: RTL and testbench
=======================================

MSGPU_MEMORY_ARBITER -- requirements
Module: msgpu_memory_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 21, word address width of the PSRAM port.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, memory word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive display wins after which a pending host request takes priority.
REQ-004 SHALL have port system_clock, input, 1 -- the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 -- asynchronous, active-low reset.
REQ-006 SHALL have port display_request, input, 1 -- display line-fetch read pending; held with its fields until granted.
REQ-007 SHALL have port display_address, input, ADDRESS_WIDTH -- burst start address.
REQ-008 SHALL have port display_burst, input, 3 -- burst length minus one (1..8 words).
REQ-009 SHALL have port display_grant, output, 1 -- one-cycle pulse on display command acceptance.
REQ-010 SHALL have port display_data, output, DATA_WIDTH -- display read word.
REQ-011 SHALL have port display_data_valid, output, 1 -- display_data qualifier.
REQ-012 SHALL have port host_request, input, 1 -- host access pending; held until granted.
REQ-013 SHALL have port host_write, input, 1 -- 1 = write, 0 = read; single word only.
REQ-014 SHALL have port host_address, input, ADDRESS_WIDTH -- host word address.
REQ-015 SHALL have port host_write_data, input, DATA_WIDTH -- host write word.
REQ-016 SHALL have port host_grant, output, 1 -- one-cycle pulse on host command acceptance.
REQ-017 SHALL have port host_read_data, output, DATA_WIDTH -- host read word.
REQ-018 SHALL have port host_read_data_valid, output, 1 -- host_read_data qualifier.
REQ-019 SHALL have port mem_command_valid, output, 1 -- command to PSRAM controller.
REQ-020 SHALL have port mem_command_ready, input, 1 -- controller accepts the command when valid and ready are both high.
REQ-021 SHALL have ports mem_write (output, 1), mem_address (output, ADDRESS_WIDTH), mem_write_data (output, DATA_WIDTH) and mem_burst (output, 3) -- command fields.
REQ-022 SHALL have port mem_read_data, input, DATA_WIDTH -- returned read word.
REQ-023 SHALL have port mem_read_data_valid, input, 1 -- mem_read_data qualifier.

Function
REQ-024 SHALL implement FSM IDLE -> ISSUE -> (READ_WAIT for reads | IDLE for writes) -> IDLE.
REQ-025 IDLE: with any request pending SHALL latch the winner's fields and owner, then enter ISSUE the next cycle.
REQ-026 Winner selection: display SHALL win unless a host request is pending and the skip counter equals STARVE_LIMIT, in which case host wins.
REQ-027 Skip counter SHALL increment on each display win while host_request is high, saturate at STARVE_LIMIT, and clear on any host win.
REQ-028 ISSUE: mem_command_valid SHALL be high and command fields SHALL be stable until mem_command_ready is high.
REQ-029 On acceptance, the owner's grant SHALL pulse for exactly one cycle, in the acceptance cycle.
REQ-030 Host writes SHALL set mem_burst = 0 and mem_write = 1; host reads SHALL set mem_burst = 0.
REQ-031 Display commands SHALL set mem_write = 0 and mem_burst = display_burst.
REQ-032 After read acceptance, SHALL load beat counter = mem_burst + 1 and enter READ_WAIT.
REQ-033 READ_WAIT: each mem_read_data_valid SHALL be forwarded combinationally, with zero latency, to the owner's data and valid outputs only, and SHALL decrement the counter.
REQ-034 On the last beat, SHALL return to IDLE; a new request SHALL not be latched in that same cycle.
REQ-035 mem_read_data_valid in IDLE or ISSUE SHALL be ignored, with no output valid.
REQ-036 Simultaneous display_request and host_request with skip counter below the limit: display SHALL win and the counter SHALL increment.
REQ-037 Requests deasserted before grant are a protocol violation; behaviour is unspecified, but the FSM SHALL still complete the latched command.
REQ-038 Worst-case request-to-command latency from IDLE SHALL be 2 cycles plus controller stall.

Reset
REQ-039 reset_n low SHALL asynchronously force IDLE, the beat counter to 0, the skip counter to 0, and all outputs to 0.
REQ-040 Reset mid-burst SHALL abandon the transaction; residual mem_read_data_valid after release SHALL be ignored per REQ-035.
REQ-041 Reset release SHALL be synchronized externally; the block adds no synchronizer.

Structure
REQ-042 Shared package msgpu_pkg SHALL hold the FSM state enum, burst-field width (3) and default widths.
REQ-043 A sub-module msgpu_priority_select SHALL contain the winner selection and skip counter; the FSM and datapath remain in the top module.

Verification
REQ-044 Display-only request, address 0x00100, burst 7, ready always high -> grant at cycle 2 and 8 display_data_valid beats, no host valid.
REQ-045 Host write to 0x1FFFFF, data 0xBEEF, ready low for 3 cycles -> fields stable throughout and host_grant on the 4th ISSUE cycle, with mem_write=1 and mem_burst=0.
REQ-046 Display and host requesting continuously -> grant order D,D,D,D,H, repeating.
REQ-047 Host read of 0x00042 returning 0x1234 -> host_read_data_valid once with 0x1234, display_data_valid stays 0.
REQ-048 reset_n low after 3 of 8 beats, then 5 stray valids after release -> all outputs 0, FSM in IDLE, no data forwarded.
REQ-049 mem_read_data_valid pulsed in IDLE -> no valid output and no state change.

Source files
------------

// File: rtl/msgpu_pkg.sv
// Shared types and widths for the MSGPU memory arbiter: FSM state encoding,
// request owner and the burst/beat field widths.
package msgpu_pkg;

    localparam int BURST_WIDTH           = 3;
    localparam int BEAT_WIDTH            = BURST_WIDTH + 1;
    localparam int DEFAULT_ADDRESS_WIDTH = 21;
    localparam int DEFAULT_DATA_WIDTH    = 16;
    localparam int DEFAULT_STARVE_LIMIT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_READ_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_DISPLAY = 1'b0,
        OWNER_HOST    = 1'b1
    } owner_t;

endpackage

// File: rtl/msgpu_priority_select.sv
// Display-first winner selection with a skip counter that lets a waiting host
// through after STARVE_LIMIT consecutive display wins.
module msgpu_priority_select
    import msgpu_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic   system_clock,
    input  logic   reset_n,
    input  logic   display_request,
    input  logic   host_request,
    input  logic   select_enable,
    output owner_t winner
);

    localparam int SKIP_WIDTH = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SKIP_WIDTH-1:0] SKIP_MAX = SKIP_WIDTH'(STARVE_LIMIT);

    logic [SKIP_WIDTH-1:0] skip_count;

    always_comb begin
        winner = OWNER_DISPLAY;
        if (host_request && (!display_request || skip_count == SKIP_MAX))
            winner = OWNER_HOST;
    end

    // Only display wins that bypass a waiting host count toward starvation.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            skip_count <= '0;
        end else if (select_enable && (display_request || host_request)) begin
            if (winner == OWNER_HOST)
                skip_count <= '0;
            else if (host_request && skip_count != SKIP_MAX)
                skip_count <= skip_count + 1'b1;
        end
    end

endmodule

// File: rtl/msgpu_memory_arbiter.sv
// Arbitrates display line fetches and host single-word accesses onto one PSRAM
// controller command port, routing returned read beats back to the owner.
module msgpu_memory_arbiter
    import msgpu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int STARVE_LIMIT  = DEFAULT_STARVE_LIMIT
) (
    input  logic                     system_clock,
    input  logic                     reset_n,
    input  logic                     display_request,
    input  logic [ADDRESS_WIDTH-1:0] display_address,
    input  logic [BURST_WIDTH-1:0]   display_burst,
    output logic                     display_grant,
    output logic [DATA_WIDTH-1:0]    display_data,
    output logic                     display_data_valid,
    input  logic                     host_request,
    input  logic                     host_write,
    input  logic [ADDRESS_WIDTH-1:0] host_address,
    input  logic [DATA_WIDTH-1:0]    host_write_data,
    output logic                     host_grant,
    output logic [DATA_WIDTH-1:0]    host_read_data,
    output logic                     host_read_data_valid,
    output logic                     mem_command_valid,
    input  logic                     mem_command_ready,
    output logic                     mem_write,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic [BURST_WIDTH-1:0]   mem_burst,
    input  logic [DATA_WIDTH-1:0]    mem_read_data,
    input  logic                     mem_read_data_valid
);

    arb_state_t               state, next_state;
    owner_t                   owner, winner;
    logic                     cmd_write;
    logic [ADDRESS_WIDTH-1:0] cmd_address;
    logic [DATA_WIDTH-1:0]    cmd_write_data;
    logic [BURST_WIDTH-1:0]   cmd_burst;
    logic [BEAT_WIDTH-1:0]    beat_count;

    logic pending, latch, issuing, accept, beat, last_beat;

    assign pending   = display_request || host_request;
    assign latch     = (state == ST_IDLE) && pending;
    assign issuing   = (state == ST_ISSUE);
    assign accept    = issuing && mem_command_ready;
    assign beat      = (state == ST_READ_WAIT) && mem_read_data_valid;
    assign last_beat = beat && (beat_count == BEAT_WIDTH'(1));

    msgpu_priority_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_priority_select (
        .system_clock    (system_clock),
        .reset_n         (reset_n),
        .display_request (display_request),
        .host_request    (host_request),
        .select_enable   (state == ST_IDLE),
        .winner          (winner)
    );

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (pending)   next_state = ST_ISSUE;
            ST_ISSUE:     if (accept)    next_state = cmd_write ? ST_IDLE : ST_READ_WAIT;
            ST_READ_WAIT: if (last_beat) next_state = ST_IDLE;
            default:                     next_state = ST_IDLE;
        endcase
    end

    // Command fields are captured once in IDLE so they hold steady while stalled.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            owner          <= OWNER_DISPLAY;
            cmd_write      <= 1'b0;
            cmd_address    <= '0;
            cmd_write_data <= '0;
            cmd_burst      <= '0;
            beat_count     <= '0;
        end else begin
            if (latch) begin
                owner <= winner;
                if (winner == OWNER_HOST) begin
                    cmd_write      <= host_write;
                    cmd_address    <= host_address;
                    cmd_write_data <= host_write_data;
                    cmd_burst      <= '0;
                end else begin
                    cmd_write      <= 1'b0;
                    cmd_address    <= display_address;
                    cmd_write_data <= '0;
                    cmd_burst      <= display_burst;
                end
            end
            if (accept && !cmd_write)
                beat_count <= BEAT_WIDTH'(cmd_burst) + BEAT_WIDTH'(1);
            else if (beat)
                beat_count <= beat_count - BEAT_WIDTH'(1);
        end
    end

    assign mem_command_valid = issuing;
    assign mem_write         = issuing && cmd_write;
    assign mem_address       = issuing ? cmd_address    : '0;
    assign mem_write_data    = issuing ? cmd_write_data : '0;
    assign mem_burst         = issuing ? cmd_burst      : '0;

    assign display_grant = accept && (owner == OWNER_DISPLAY);
    assign host_grant    = accept && (owner == OWNER_HOST);

    // Read beats bypass any register so the owner sees them in the same cycle.
    assign display_data_valid   = beat && (owner == OWNER_DISPLAY);
    assign host_read_data_valid = beat && (owner == OWNER_HOST);
    assign display_data         = display_data_valid   ? mem_read_data : '0;
    assign host_read_data       = host_read_data_valid ? mem_read_data : '0;

endmodule

// File: tb/tb_msgpu_memory_arbiter.sv
// Directed bench for msgpu_memory_arbiter: display burst, stalled host write,
// host read, starvation rotation, mid-burst reset and stray read beats.
module tb_msgpu_memory_arbiter;

    localparam int AW = 21;
    localparam int DW = 16;

    logic          system_clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          display_request = 1'b0;
    logic [AW-1:0] display_address = '0;
    logic [2:0]    display_burst = '0;
    logic          display_grant;
    logic [DW-1:0] display_data;
    logic          display_data_valid;
    logic          host_request = 1'b0;
    logic          host_write = 1'b0;
    logic [AW-1:0] host_address = '0;
    logic [DW-1:0] host_write_data = '0;
    logic          host_grant;
    logic [DW-1:0] host_read_data;
    logic          host_read_data_valid;
    logic          mem_command_valid;
    logic          mem_command_ready = 1'b1;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic [2:0]    mem_burst;
    logic [DW-1:0] mem_read_data = '0;
    logic          mem_read_data_valid = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    msgpu_memory_arbiter dut (
        .system_clock         (system_clock),
        .reset_n              (reset_n),
        .display_request      (display_request),
        .display_address      (display_address),
        .display_burst        (display_burst),
        .display_grant        (display_grant),
        .display_data         (display_data),
        .display_data_valid   (display_data_valid),
        .host_request         (host_request),
        .host_write           (host_write),
        .host_address         (host_address),
        .host_write_data      (host_write_data),
        .host_grant           (host_grant),
        .host_read_data       (host_read_data),
        .host_read_data_valid (host_read_data_valid),
        .mem_command_valid    (mem_command_valid),
        .mem_command_ready    (mem_command_ready),
        .mem_write            (mem_write),
        .mem_address          (mem_address),
        .mem_write_data       (mem_write_data),
        .mem_burst            (mem_burst),
        .mem_read_data        (mem_read_data),
        .mem_read_data_valid  (mem_read_data_valid)
    );

    always #5 system_clock = ~system_clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge system_clock);
        #1;
    endtask

    // Counts falling edges until a grant is seen; the bound keeps the bench from hanging.
    task automatic wait_grant(output logic is_host, output int cycles);
        logic found;
        found   = 1'b0;
        is_host = 1'b0;
        cycles  = 0;
        while (!found && cycles < 20) begin
            @(negedge system_clock);
            cycles++;
            if (display_grant || host_grant) begin
                found   = 1'b1;
                is_host = host_grant;
            end
        end
        check("grant_seen", 32'(found), 32'd1);
    endtask

    initial begin
        logic       h;
        int         c;
        logic [9:0] rr_expected;

        // Reset, with a stray read beat present
        mem_read_data_valid = 1'b1;
        mem_read_data       = 16'hDEAD;
        repeat (2) @(negedge system_clock);
        check("rst_cmd_valid", 32'(mem_command_valid), 32'd0);
        check("rst_grants", 32'({display_grant, host_grant}), 32'd0);
        check("rst_data_valids", 32'({display_data_valid, host_read_data_valid}), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_display_data", 32'(display_data), 32'd0);
        step();
        mem_read_data_valid = 1'b0;
        reset_n = 1'b1;

        // Display-only burst of 8 at 0x00100
        step();
        display_request = 1'b1;
        display_address = 21'h00100;
        display_burst   = 3'd7;
        wait_grant(h, c);
        check("d_grant_cycle", 32'(c), 32'd2);
        check("d_grant_owner", 32'(h), 32'd0);
        check("d_cmd_addr", 32'(mem_address), 32'h100);
        check("d_cmd_burst", 32'(mem_burst), 32'd7);
        check("d_cmd_write", 32'(mem_write), 32'd0);
        step();
        display_request = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem_read_data_valid = 1'b1;
            mem_read_data       = 16'(16'hA000 + i);
            if (i == 7) begin
                host_request = 1'b1;
                host_write   = 1'b0;
                host_address = 21'h00042;
            end
            @(negedge system_clock);
            check("d_beat_valid", 32'(display_data_valid), 32'd1);
            check("d_beat_data", 32'(display_data), 32'(16'hA000 + i));
            check("d_beat_host_quiet", 32'(host_read_data_valid), 32'd0);
            step();
        end
        mem_read_data_valid = 1'b0;

        // Host read of 0x00042; request was already up during the last display beat
        @(negedge system_clock);
        check("last_beat_no_latch", 32'(mem_command_valid), 32'd0);
        wait_grant(h, c);
        check("h_rd_grant_cycle", 32'(c), 32'd1);
        check("h_rd_owner", 32'(h), 32'd1);
        check("h_rd_addr", 32'(mem_address), 32'h42);
        check("h_rd_burst", 32'(mem_burst), 32'd0);
        check("h_rd_write", 32'(mem_write), 32'd0);
        step();
        host_request = 1'b0;
        @(negedge system_clock);
        check("h_rd_wait_quiet", 32'(host_read_data_valid), 32'd0);
        step();
        mem_read_data_valid = 1'b1;
        mem_read_data       = 16'h1234;
        @(negedge system_clock);
        check("h_rd_valid", 32'(host_read_data_valid), 32'd1);
        check("h_rd_data", 32'(host_read_data), 32'h1234);
        check("h_rd_display_quiet", 32'(display_data_valid), 32'd0);
        step();
        mem_read_data_valid = 1'b0;
        @(negedge system_clock);
        check("h_rd_done_valid", 32'(host_read_data_valid), 32'd0);
        check("h_rd_done_idle", 32'(mem_command_valid), 32'd0);

        // Host write to 0x1FFFFF stalled three cycles by the controller
        step();
        mem_command_ready = 1'b0;
        host_request      = 1'b1;
        host_write        = 1'b1;
        host_address      = 21'h1FFFFF;
        host_write_data   = 16'hBEEF;
        @(negedge system_clock);
        check("h_wr_idle_cycle", 32'(mem_command_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            mem_read_data_valid = (i == 1);
            @(negedge system_clock);
            check("h_wr_stall_valid", 32'(mem_command_valid), 32'd1);
            check("h_wr_stall_addr", 32'(mem_address), 32'h1FFFFF);
            check("h_wr_stall_data", 32'(mem_write_data), 32'hBEEF);
            check("h_wr_stall_write", 32'(mem_write), 32'd1);
            check("h_wr_stall_burst", 32'(mem_burst), 32'd0);
            check("h_wr_stall_grant", 32'(host_grant), 32'd0);
            check("h_wr_issue_ignore", 32'(host_read_data_valid), 32'd0);
        end
        step();
        mem_read_data_valid = 1'b0;
        mem_command_ready   = 1'b1;
        @(negedge system_clock);
        check("h_wr_grant", 32'(host_grant), 32'd1);
        check("h_wr_no_dgrant", 32'(display_grant), 32'd0);
        check("h_wr_write", 32'(mem_write), 32'd1);
        check("h_wr_burst", 32'(mem_burst), 32'd0);
        check("h_wr_addr", 32'(mem_address), 32'h1FFFFF);
        step();
        host_request = 1'b0;
        host_write   = 1'b0;
        @(negedge system_clock);
        check("h_wr_back_idle", 32'(mem_command_valid), 32'd0);
        check("h_wr_grant_pulse", 32'(host_grant), 32'd0);

        // Both requesting continuously: D,D,D,D,H repeating
        step();
        display_request = 1'b1;
        display_address = 21'h00200;
        display_burst   = 3'd0;
        host_request    = 1'b1;
        host_write      = 1'b1;
        host_address    = 21'h00300;
        host_write_data = 16'h5555;
        rr_expected     = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            wait_grant(h, c);
            check("rr_order", 32'(h), 32'(rr_expected[i]));
            check("rr_latency", 32'(c), 32'd2);
            if (!h) begin
                step();
                mem_read_data_valid = 1'b1;
                mem_read_data       = 16'(i);
                @(negedge system_clock);
                check("rr_display_beat", 32'(display_data_valid), 32'd1);
                step();
                mem_read_data_valid = 1'b0;
            end else begin
                step();
            end
        end
        display_request = 1'b0;
        host_request    = 1'b0;
        host_write      = 1'b0;

        // Reset after 3 of 8 beats, then stray beats after release
        step();
        display_request = 1'b1;
        display_address = 21'h00100;
        display_burst   = 3'd7;
        wait_grant(h, c);
        check("rst_burst_grant", 32'(h), 32'd0);
        step();
        display_request = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_read_data_valid = 1'b1;
            mem_read_data       = 16'(16'hC000 + i);
            @(negedge system_clock);
            check("rst_pre_beat", 32'(display_data_valid), 32'd1);
            step();
        end
        mem_read_data = 16'hC003;
        reset_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(display_data_valid), 32'd0);
        check("rst_async_data", 32'(display_data), 32'd0);
        check("rst_async_cmd", 32'(mem_command_valid), 32'd0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_read_data_valid = 1'b1;
            mem_read_data       = 16'(16'hE000 + i);
            @(negedge system_clock);
            check("stray_display_valid", 32'(display_data_valid), 32'd0);
            check("stray_host_valid", 32'(host_read_data_valid), 32'd0);
            check("stray_cmd_valid", 32'(mem_command_valid), 32'd0);
            step();
        end
        mem_read_data_valid = 1'b0;

        // Still idle: a fresh host read is granted with the normal latency
        host_request = 1'b1;
        host_write   = 1'b0;
        host_address = 21'h00042;
        wait_grant(h, c);
        check("post_rst_latency", 32'(c), 32'd2);
        check("post_rst_owner", 32'(h), 32'd1);
        step();
        host_request        = 1'b0;
        mem_read_data_valid = 1'b1;
        mem_read_data       = 16'h0BAD;
        @(negedge system_clock);
        check("post_rst_rd_data", 32'(host_read_data), 32'h0BAD);
        step();
        mem_read_data_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
